ndp_stream_ctrl: RTL and testbench

//  Job-level controller for the near-data-processing path. Accepts a 32-bit valid/ready word stream for a job of

---
 rtl/ndp_pkg.sv | 32 +++
 rtl/ndp_sp_addr_gen.sv | 58 +++++
 rtl/ndp_stream_ctrl.sv | 152 +++++++++++++++
 tb/tb_ndp_stream_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ndp_pkg.sv
// Shared definitions for the near-data-processing stream controller: FSM encoding,
// scratch-pad select values, SIMD mode encodings and index-width helpers.
package ndp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_ACT,
        ST_LOAD_WGT,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN,
        ST_RESULT
    } state_t;

    localparam logic SP_SEL_ACT = 1'b0;
    localparam logic SP_SEL_WGT = 1'b1;

    localparam logic [1:0] MODE_FP16 = 2'b00;
    localparam logic [1:0] MODE_BF16 = 2'b01;
    localparam logic [1:0] MODE_INT8 = 2'b10;
    localparam logic [1:0] MODE_INT4 = 2'b11;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_LAYER_W = idx_w(5);
    localparam int DEF_BANK_W  = idx_w(64);
    localparam int DEF_ADDR_W  = idx_w(2);

endpackage

// File: rtl/ndp_sp_addr_gen.sv
// Scratch-pad layer/bank/word counter. Steps one word per beat and wraps the bank
// at the end of the activation or weight region selected by sel.
module ndp_sp_addr_gen
    import ndp_pkg::*;
#(
    parameter  int DEPTH     = 5,
    parameter  int ACT_BANKS = 1,
    parameter  int WGT_BANKS = 64,
    parameter  int WPB       = 2,
    localparam int LW        = idx_w(DEPTH),
    localparam int BW        = idx_w(WGT_BANKS),
    localparam int AW        = idx_w(WPB)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          step,
    input  logic          sel,
    output logic [LW-1:0] layer,
    output logic [BW-1:0] bank,
    output logic [AW-1:0] addr,
    output logic          act_last,
    output logic          wgt_last,
    output logic          layer_last
);

    logic addr_last;

    assign addr_last  = (addr == AW'(WPB - 1));
    assign act_last   = addr_last && (bank == BW'(ACT_BANKS - 1));
    assign wgt_last   = addr_last && (bank == BW'(WGT_BANKS - 1));
    assign layer_last = (layer == LW'(DEPTH - 1));

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            layer <= '0;
            bank  <= '0;
            addr  <= '0;
        end else if (step) begin
            if (!addr_last) begin
                addr <= addr + AW'(1);
            end else begin
                addr <= '0;
                if (sel == SP_SEL_WGT ? wgt_last : act_last) begin
                    bank <= '0;
                    // A finished layer moves on; the last layer wraps so the pad is reused.
                    if (sel == SP_SEL_WGT)
                        layer <= layer_last ? '0 : layer + LW'(1);
                end else begin
                    bank <= bank + BW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ndp_stream_ctrl.sv
// Job-level controller: loads a valid/ready word stream into the scratch pad layer by
// layer, feeds buffered layers to the NDP unit in passes, and hands off the result.
module ndp_stream_ctrl
    import ndp_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int DEPTH     = 5,
    parameter  int ACT_BANKS = 1,
    parameter  int WGT_BANKS = 64,
    parameter  int WPB       = 2,
    parameter  int CNT_W     = 16,
    localparam int LW        = idx_w(DEPTH),
    localparam int BW        = idx_w(WGT_BANKS),
    localparam int AW        = idx_w(WPB),
    localparam int LDW       = idx_w(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  tile_count,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sp_we,
    output logic              sp_sel,
    output logic [LW-1:0]     sp_layer,
    output logic [BW-1:0]     sp_bank,
    output logic [AW-1:0]     sp_addr,
    output logic [DATA_W-1:0] sp_wdata,
    output logic              feed_en,
    output logic [LW-1:0]     feed_layer,
    output logic [1:0]        unit_mode,
    output logic              unit_last,
    input  logic              unit_done,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              done
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] remaining;
    logic [LDW-1:0]   loaded;
    logic [LW-1:0]    feed_idx;
    logic             feed_started;
    logic             beat, job_go, feed_end;
    logic [LW-1:0]    layer;
    logic [BW-1:0]    bank;
    logic [AW-1:0]    addr;
    logic             act_last, wgt_last, layer_last;

    assign in_ready  = (state == ST_LOAD_ACT) || (state == ST_LOAD_WGT);
    assign beat      = in_valid && in_ready;
    assign job_go    = (state == ST_IDLE) && start && (tile_count != '0);
    // The first FEED cycle is a bubble so the last write lands before it is read back.
    assign feed_en   = (state == ST_FEED) && feed_started;
    assign feed_layer = feed_en ? feed_idx : '0;
    assign feed_end  = feed_en && (LDW'(feed_idx) + LDW'(1) == loaded);
    assign unit_last = (state == ST_FLUSH);
    assign busy      = (state != ST_IDLE);
    assign res_valid = (state == ST_RESULT);

    ndp_sp_addr_gen #(
        .DEPTH    (DEPTH),
        .ACT_BANKS(ACT_BANKS),
        .WGT_BANKS(WGT_BANKS),
        .WPB      (WPB)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (job_go),
        .step      (beat),
        .sel       (state == ST_LOAD_WGT),
        .layer     (layer),
        .bank      (bank),
        .addr      (addr),
        .act_last  (act_last),
        .wgt_last  (wgt_last),
        .layer_last(layer_last)
    );

    // NOTE: state_nx gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:     if (job_go) state_nx = ST_LOAD_ACT;
            ST_LOAD_ACT: if (beat && act_last) state_nx = ST_LOAD_WGT;
            ST_LOAD_WGT: if (beat && wgt_last)
                             state_nx = (layer_last || remaining == CNT_W'(1)) ? ST_FEED : ST_LOAD_ACT;
            ST_FEED:     if (feed_end) state_nx = (remaining != '0) ? ST_LOAD_ACT : ST_FLUSH;
            ST_FLUSH:    state_nx = ST_DRAIN;
            ST_DRAIN:    if (unit_done) state_nx = ST_RESULT;
            ST_RESULT:   if (res_ready) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            loaded       <= '0;
            unit_mode    <= MODE_FP16;
            feed_started <= 1'b0;
            feed_idx     <= '0;
            done         <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= res_valid && res_ready;
            if (job_go) begin
                remaining <= tile_count;
                unit_mode <= mode;
            end
            if (state == ST_LOAD_WGT && beat && wgt_last) begin
                remaining <= remaining - CNT_W'(1);
                loaded    <= LDW'(layer) + LDW'(1);
            end
            if (state != ST_FEED) begin
                feed_started <= 1'b0;
                feed_idx     <= '0;
            end else if (!feed_started) begin
                feed_started <= 1'b1;
            end else begin
                feed_idx <= feed_idx + LW'(1);
            end
        end
    end

    // Write stage: each beat is presented to the scratch pad exactly one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_we    <= 1'b0;
            sp_sel   <= SP_SEL_ACT;
            sp_layer <= '0;
            sp_bank  <= '0;
            sp_addr  <= '0;
            sp_wdata <= '0;
        end else begin
            sp_we <= beat;
            if (beat) begin
                sp_sel   <= (state == ST_LOAD_WGT) ? SP_SEL_WGT : SP_SEL_ACT;
                sp_layer <= layer;
                sp_bank  <= bank;
                sp_addr  <= addr;
                sp_wdata <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_ndp_stream_ctrl.sv
// Self-checking bench for ndp_stream_ctrl: randomized stream jobs on a small instance
// compared against a layer/pass-level model, plus one default-sized run.
module tb_ndp_stream_ctrl;
    import ndp_pkg::*;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 2;
    localparam int ACT_BANKS = 1;
    localparam int WGT_BANKS = 2;
    localparam int WPB       = 2;
    localparam int CNT_W     = 16;
    localparam int BPL       = (ACT_BANKS + WGT_BANKS) * WPB;

    logic              clk, reset;
    logic              start, in_valid, unit_done, res_ready;
    logic [CNT_W-1:0]  tile_count;
    logic [1:0]        mode;
    logic [DATA_W-1:0] in_data;
    logic              in_ready, sp_we, sp_sel, feed_en, unit_last, busy, res_valid, done;
    logic [0:0]        sp_layer, sp_bank, sp_addr, feed_layer;
    logic [DATA_W-1:0] sp_wdata;
    logic [1:0]        unit_mode;

    logic              d_start, d_in_valid, d_unit_done, d_res_ready;
    logic [15:0]       d_tile_count;
    logic [1:0]        d_mode;
    logic [31:0]       d_in_data;
    logic              d_in_ready, d_sp_we, d_sp_sel, d_feed_en, d_unit_last, d_busy, d_res_valid, d_done;
    logic [2:0]        d_sp_layer, d_feed_layer;
    logic [5:0]        d_sp_bank;
    logic [0:0]        d_sp_addr;
    logic [31:0]       d_sp_wdata;
    logic [1:0]        d_unit_mode;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ndp_stream_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ACT_BANKS(ACT_BANKS),
        .WGT_BANKS(WGT_BANKS), .WPB(WPB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .tile_count(tile_count), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .sp_we(sp_we), .sp_sel(sp_sel), .sp_layer(sp_layer), .sp_bank(sp_bank),
        .sp_addr(sp_addr), .sp_wdata(sp_wdata), .feed_en(feed_en), .feed_layer(feed_layer),
        .unit_mode(unit_mode), .unit_last(unit_last), .unit_done(unit_done), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .done(done)
    );

    ndp_stream_ctrl dut_def (
        .clk(clk), .reset(reset), .start(d_start), .tile_count(d_tile_count), .mode(d_mode),
        .in_valid(d_in_valid), .in_data(d_in_data), .in_ready(d_in_ready),
        .sp_we(d_sp_we), .sp_sel(d_sp_sel), .sp_layer(d_sp_layer), .sp_bank(d_sp_bank),
        .sp_addr(d_sp_addr), .sp_wdata(d_sp_wdata), .feed_en(d_feed_en), .feed_layer(d_feed_layer),
        .unit_mode(d_unit_mode), .unit_last(d_unit_last), .unit_done(d_unit_done), .busy(d_busy),
        .res_valid(d_res_valid), .res_ready(d_res_ready), .done(d_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Expected write record for stream word j: {sel, layer, bank, addr, data}.
    function automatic logic [63:0] exp_write(input int j, input logic [31:0] d);
        int t, w, sel, bk, ad;
        t = j / BPL;
        w = j % BPL;
        if (w < ACT_BANKS * WPB) begin
            sel = 0; bk = w / WPB; ad = w % WPB;
        end else begin
            w = w - ACT_BANKS * WPB;
            sel = 1; bk = w / WPB; ad = w % WPB;
        end
        return {7'd0, 1'(sel), 8'(t % DEPTH), 8'(bk), 8'(ad), d};
    endfunction

    // vmode: 0 = continuous valid, 1 = toggling, 2 = random.
    task automatic run_job(input int t_cnt, input int vmode, input bit disturb, input logic [1:0] m);
        int nb, idx, guard, lb, first, len, mode_at_last;
        bit toggle, sdone, udone;
        logic [31:0] data[$];
        int beat_cyc[$], wr_cyc[$], f_cyc[$], f_lay[$], l_cyc[$], ef_cyc[$], ef_lay[$];
        logic [63:0] wr_rec[$];
        int exp_last;

        nb = t_cnt * BPL;
        for (int i = 0; i < nb; i++) data.push_back($urandom);
        idx = 0; guard = 0; toggle = 1'b1; sdone = 1'b0; udone = 1'b0;
        mode_at_last = -1; exp_last = -1;

        start = 1'b1; tile_count = CNT_W'(t_cnt); mode = m;
        tick();
        start = 1'b0; tile_count = CNT_W'($urandom); mode = 2'($urandom);

        while (l_cyc.size() == 0 && guard < 4000) begin
            if (sp_we) begin
                wr_cyc.push_back(cyc);
                wr_rec.push_back({7'd0, sp_sel, 8'(sp_layer), 8'(sp_bank), 8'(sp_addr), sp_wdata});
            end
            if (feed_en) begin
                f_cyc.push_back(cyc);
                f_lay.push_back(int'(feed_layer));
            end
            if (unit_last) begin
                l_cyc.push_back(cyc);
                mode_at_last = int'(unit_mode);
            end
            case (vmode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = toggle; toggle = ~toggle; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (idx >= nb) in_valid = 1'b0;
            in_data = in_valid ? data[idx] : $urandom;
            start = 1'b0;
            unit_done = 1'b0;
            if (disturb && idx == 3 && !sdone) begin
                start = 1'b1; tile_count = CNT_W'(1); sdone = 1'b1;
            end
            if (disturb && idx == 4 && !udone) begin
                unit_done = 1'b1; udone = 1'b1;
            end
            if (in_valid && in_ready) begin
                beat_cyc.push_back(cyc);
                idx++;
            end
            tick();
            guard++;
        end
        in_valid = 1'b0; start = 1'b0; unit_done = 1'b0;

        check("job_timeout", 64'(guard < 4000), 64'd1);
        check("beat_count", 64'(beat_cyc.size()), 64'(nb));
        check("write_count", 64'(wr_rec.size()), 64'(nb));
        if (beat_cyc.size() == nb && wr_rec.size() == nb) begin
            for (int j = 0; j < nb; j++) begin
                check($sformatf("write_lat[%0d]", j), 64'(wr_cyc[j]), 64'(beat_cyc[j] + 1));
                check($sformatf("write_rec[%0d]", j), wr_rec[j], exp_write(j, data[j]));
            end
            for (int p = 0; p * DEPTH < t_cnt; p++) begin
                first = p * DEPTH;
                len = (t_cnt - first < DEPTH) ? t_cnt - first : DEPTH;
                lb = beat_cyc[(first + len) * BPL - 1];
                for (int i = 0; i < len; i++) begin
                    ef_cyc.push_back(lb + 2 + i);
                    ef_lay.push_back(i);
                end
                exp_last = lb + 2 + len;
            end
            check("feed_count", 64'(f_cyc.size()), 64'(ef_cyc.size()));
            if (f_cyc.size() == ef_cyc.size()) begin
                for (int i = 0; i < ef_cyc.size(); i++) begin
                    check($sformatf("feed_cyc[%0d]", i), 64'(f_cyc[i]), 64'(ef_cyc[i]));
                    check($sformatf("feed_layer[%0d]", i), 64'(f_lay[i]), 64'(ef_lay[i]));
                end
            end
        end
        check("last_count", 64'(l_cyc.size()), 64'd1);
        if (l_cyc.size() == 1 && exp_last >= 0)
            check("last_cyc", 64'(l_cyc[0]), 64'(exp_last));
        check("unit_mode", 64'(mode_at_last), 64'(m));

        for (int i = 0; i < 3; i++) begin
            check("drain_res_valid", 64'(res_valid), 64'd0);
            check("drain_busy", 64'(busy), 64'd1);
            tick();
        end
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        check("res_valid_up", 64'(res_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("res_valid_held", 64'(res_valid), 64'd1);
            check("done_quiet", 64'(done), 64'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("done_pulse", 64'(done), 64'd1);
        check("busy_drop", 64'(busy), 64'd0);
        check("res_valid_drop", 64'(res_valid), 64'd0);
        tick();
        check("done_single", 64'(done), 64'd0);
    endtask

    initial begin
        int idx, guard, nwr, didx;
        logic [63:0] last_rec;
        bit seen_last;

        reset = 1'b1; start = 1'b0; tile_count = '0; mode = '0; in_valid = 1'b0;
        in_data = '0; unit_done = 1'b0; res_ready = 1'b0;
        d_start = 1'b0; d_tile_count = '0; d_mode = '0; d_in_valid = 1'b0;
        d_in_data = '0; d_unit_done = 1'b0; d_res_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_sp_we", 64'(sp_we), 64'd0);
        check("rst_feed_en", 64'(feed_en), 64'd0);
        check("rst_unit_last", 64'(unit_last), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_unit_mode", 64'(unit_mode), 64'd0);
        reset = 1'b0;
        tick();

        // Zero-length start is ignored.
        start = 1'b1; tile_count = '0;
        tick();
        start = 1'b0;
        check("zero_start_busy", 64'(busy), 64'd0);
        check("zero_start_ready", 64'(in_ready), 64'd0);
        tick();
        check("zero_start_we", 64'(sp_we), 64'd0);

        run_job(1, 0, 1'b0, MODE_INT8);
        run_job(3, 0, 1'b0, MODE_BF16);
        run_job(3, 1, 1'b1, MODE_INT4);
        run_job(4, 2, 1'b0, MODE_FP16);

        // Reset on the 4th beat aborts the job and drops the pending write.
        start = 1'b1; tile_count = CNT_W'(2);
        tick();
        start = 1'b0; idx = 0; guard = 0;
        while (idx < 3 && guard < 100) begin
            in_valid = 1'b1; in_data = $urandom;
            if (in_ready) idx++;
            tick();
            guard++;
        end
        check("pre_reset_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_data = $urandom; reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        check("abort_sp_we", 64'(sp_we), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_feed_en", 64'(feed_en), 64'd0);
        tick();
        run_job(2, 2, 1'b0, MODE_BF16);

        // Default-sized instance: one full layer is 130 writes.
        d_start = 1'b1; d_tile_count = 16'd1; d_mode = MODE_INT8;
        tick();
        d_start = 1'b0; guard = 0; nwr = 0; didx = 0; seen_last = 1'b0; last_rec = '0;
        while (!seen_last && guard < 1000) begin
            if (d_sp_we) begin
                nwr++;
                last_rec = {7'd0, d_sp_sel, 8'(d_sp_layer), 8'(d_sp_bank), 8'(d_sp_addr), d_sp_wdata};
            end
            if (d_unit_last) seen_last = 1'b1;
            d_in_valid = 1'b1;
            d_in_data = 32'(didx);
            if (d_in_ready) didx++;
            tick();
            guard++;
        end
        d_in_valid = 1'b0;
        check("def_unit_last", 64'(seen_last), 64'd1);
        check("def_write_count", 64'(nwr), 64'd130);
        check("def_last_write", last_rec, {7'd0, 1'b1, 8'd0, 8'd63, 8'd1, 32'd129});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
